// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// One bit per CLK cycle. TX_OUT and Busy come straight from flops.
//   state  | meaning
//   IDLE   | line high, waiting for Data_Valid
//   START  | start bit (low) on the line
//   DATA   | data bits, shift[0] on the line
//   PARITY | captured parity bit on the line
//   STOP   | stop bit (high); Data_Valid here chains the next frame
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  nRESET,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] shift, shift_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  par_en_q, par_en_nxt;
  logic                  par_q, par_nxt;
  logic                  tx_nxt, busy_nxt;
  logic                  take;

  // A new byte is accepted only from IDLE or at the edge that ends STOP.
  assign take = Data_Valid && ((state == IDLE) || (state == STOP));

  always_comb begin
    state_nxt  = state;
    shift_nxt  = shift;
    cnt_nxt    = cnt;
    par_en_nxt = par_en_q;
    par_nxt    = par_q;

    case (state)
      IDLE:   state_nxt = IDLE;
      START:  state_nxt = DATA;
      DATA: begin
        if (cnt == LAST_BIT) begin
          cnt_nxt   = '0;
          state_nxt = par_en_q ? PARITY : STOP;
        end else begin
          cnt_nxt   = cnt + 1'b1;
          shift_nxt = shift >> 1;
        end
      end
      PARITY: state_nxt = STOP;
      STOP:   state_nxt = IDLE;
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    if (take) begin
      state_nxt  = START;
      shift_nxt  = P_DATA;
      par_en_nxt = PAR_EN;
      par_nxt    = (^P_DATA) ^ PAR_TYP;
    end
  end

  // Output values are decoded from the next state so the flops present them with no extra lag.
  always_comb begin
    tx_nxt   = 1'b1;
    busy_nxt = 1'b1;
    case (state_nxt)
      IDLE:    busy_nxt = 1'b0;
      START:   tx_nxt   = 1'b0;
      DATA:    tx_nxt   = shift_nxt[0];
      PARITY:  tx_nxt   = par_nxt;
      STOP:    tx_nxt   = 1'b1;
      default: busy_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state    <= IDLE;
      shift    <= '0;
      cnt      <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      TX_OUT   <= 1'b1;
      Busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      shift    <= shift_nxt;
      cnt      <= cnt_nxt;
      par_en_q <= par_en_nxt;
      par_q    <= par_nxt;
      TX_OUT   <= tx_nxt;
      Busy     <= busy_nxt;
    end
  end

endmodule
